// File: rtl/codificador_bcd_if.sv
// Valid/ready bundle for the packed-BCD to binary converter.
// Input words flow master->slave; results flow slave->master.
interface codificador_bcd_if #(
    parameter int DIGITOS = 2,
    parameter int ANCHO   = 7
);
    logic [4*DIGITOS-1:0] DatoEntrada;
    logic                 EntradaValida;
    logic                 EntradaLista;
    logic [ANCHO-1:0]     DatoSalida;
    logic                 SalidaValida;
    logic                 SalidaLista;
    logic                 Error;

    modport master (
        output DatoEntrada, EntradaValida, SalidaLista,
        input  EntradaLista, DatoSalida, SalidaValida, Error
    );

    modport slave (
        input  DatoEntrada, EntradaValida, SalidaLista,
        output EntradaLista, DatoSalida, SalidaValida, Error
    );
endinterface

// File: rtl/codificador_bcd.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Define CODIFICADOR_BCD_VERIFICA_EN to flag nibbles above 9 via Error.
module codificador_bcd #(
    parameter int DIGITOS = 2,
    parameter int ANCHO   = 7
) (
    input  logic               clk,
    input  logic               rst,
    codificador_bcd_if.slave   bus
);
    localparam int AW = 4 * DIGITOS;

    typedef enum logic [1:0] {
        INACTIVO,
        CONVIRTIENDO,
        LISTO
    } estado_t;

    estado_t          estado, estado_d;
    logic [AW-1:0]    desplaza, desplaza_d;
    logic [ANCHO-1:0] acc, acc_d;
    logic [2:0]       cuenta, cuenta_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic             sv_q;
    logic [3:0]       nib;

`ifdef CODIFICADOR_BCD_VERIFICA_EN
    logic err, err_d;
    logic error_q, error_d;
`endif

    assign nib = desplaza[AW-1 -: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= INACTIVO;
            desplaza <= '0;
            acc      <= '0;
            cuenta   <= '0;
            dato_q   <= '0;
            sv_q     <= 1'b0;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
            err      <= 1'b0;
            error_q  <= 1'b0;
`endif
        end else begin
            estado   <= estado_d;
            desplaza <= desplaza_d;
            acc      <= acc_d;
            cuenta   <= cuenta_d;
            dato_q   <= dato_d;
            sv_q     <= (estado_d == LISTO);
`ifdef CODIFICADOR_BCD_VERIFICA_EN
            err      <= err_d;
            error_q  <= error_d;
`endif
        end
    end

    always_comb begin
        estado_d   = estado;
        desplaza_d = desplaza;
        acc_d      = acc;
        cuenta_d   = cuenta;
        dato_d     = dato_q;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
        err_d      = err;
        error_d    = error_q;
`endif
        unique case (estado)
            INACTIVO: begin
                if (bus.EntradaValida) begin
                    desplaza_d = bus.DatoEntrada;
                    acc_d      = '0;
                    cuenta_d   = 3'(DIGITOS);
                    estado_d   = CONVIRTIENDO;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
                    err_d      = 1'b0;
`endif
                end
            end
            CONVIRTIENDO: begin
                // acc*10 + digit, wrapping at ANCHO bits
                acc_d      = (acc << 3) + (acc << 1) + ANCHO'(nib);
                desplaza_d = desplaza << 4;
                cuenta_d   = cuenta - 3'd1;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
                err_d      = err | (nib > 4'd9);
`endif
                if (cuenta == 3'd1) begin
                    estado_d = LISTO;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
                    dato_d   = err_d ? '0 : acc_d;
                    error_d  = err_d;
`else
                    dato_d   = acc_d;
`endif
                end
            end
            LISTO: begin
                if (bus.SalidaLista) estado_d = INACTIVO;
            end
            default: estado_d = INACTIVO;
        endcase
    end

    assign bus.EntradaLista = (estado == INACTIVO);
    assign bus.SalidaValida = sv_q;
    assign bus.DatoSalida   = dato_q;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
    assign bus.Error        = error_q;
`else
    assign bus.Error        = 1'b0;
`endif
endmodule

// File: tb/tb_codificador_bcd.sv
// Directed bench for codificador_bcd with DIGITOS=2, ANCHO=7.
module tb_codificador_bcd;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    codificador_bcd_if #(.DIGITOS(2), .ANCHO(7)) bus ();

    codificador_bcd #(.DIGITOS(2), .ANCHO(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.DatoEntrada   = '0;
        bus.EntradaValida = 1'b0;
        bus.SalidaLista   = 1'b1;
        rst = 1'b1;
        #3;
        checks++;
        if (bus.EntradaLista !== 1'b1)
            $display("FAIL reset_lista got=%b exp=1", bus.EntradaLista);
        else passed++;
        checks++;
        if (bus.SalidaValida !== 1'b0)
            $display("FAIL reset_valida got=%b exp=0", bus.SalidaValida);
        else passed++;
        checks++;
        if (bus.DatoSalida !== 7'd0)
            $display("FAIL reset_dato got=%0d exp=0", bus.DatoSalida);
        else passed++;
        checks++;
        if (bus.Error !== 1'b0)
            $display("FAIL reset_error got=%b exp=0", bus.Error);
        else passed++;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basico();
        bus.SalidaLista   = 1'b1;
        bus.DatoEntrada   = 8'h15;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        bus.DatoEntrada   = 8'h88;
        checks++;
        if (bus.EntradaLista !== 1'b0 || bus.SalidaValida !== 1'b0)
            $display("FAIL basico_busy lista=%b valida=%b exp=0/0",
                     bus.EntradaLista, bus.SalidaValida);
        else passed++;
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b0)
            $display("FAIL basico_early got=%b exp=0", bus.SalidaValida);
        else passed++;
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b1 || bus.DatoSalida !== 7'd15
            || bus.Error !== 1'b0)
            $display("FAIL basico_result v=%b d=%0d e=%b exp=1/15/0",
                     bus.SalidaValida, bus.DatoSalida, bus.Error);
        else passed++;
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b0 || bus.EntradaLista !== 1'b1)
            $display("FAIL basico_done v=%b l=%b exp=0/1",
                     bus.SalidaValida, bus.EntradaLista);
        else passed++;
    endtask

    task automatic test_barrido();
        bus.SalidaLista = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int u = 0; u < 10; u++) begin
                int lat;
                int exp_v;
                exp_v = 10 * t + u;
                checks++;
                if (bus.EntradaLista !== 1'b1)
                    $display("FAIL barrido_lista word=%0d%0d got=%b exp=1",
                             t, u, bus.EntradaLista);
                else passed++;
                bus.DatoEntrada   = {4'(t), 4'(u)};
                bus.EntradaValida = 1'b1;
                tick();
                bus.EntradaValida = 1'b0;
                lat = 0;
                while (bus.SalidaValida !== 1'b1 && lat < 10) begin
                    tick();
                    lat++;
                end
                checks++;
                if (lat != 2)
                    $display("FAIL barrido_lat word=%0d%0d got=%0d exp=2",
                             t, u, lat);
                else passed++;
                checks++;
                if (bus.DatoSalida !== 7'(exp_v) || bus.Error !== 1'b0)
                    $display("FAIL barrido_val got=%0d/%b exp=%0d/0",
                             bus.DatoSalida, bus.Error, exp_v);
                else passed++;
                tick();
            end
        end
    endtask

    task automatic test_error();
        bus.SalidaLista   = 1'b1;
        bus.DatoEntrada   = 8'h1A;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        tick();
        tick();
        checks++;
`ifdef CODIFICADOR_BCD_VERIFICA_EN
        if (bus.SalidaValida !== 1'b1 || bus.Error !== 1'b1
            || bus.DatoSalida !== 7'd0)
            $display("FAIL error_1A v=%b e=%b d=%0d exp=1/1/0",
                     bus.SalidaValida, bus.Error, bus.DatoSalida);
        else passed++;
`else
        if (bus.SalidaValida !== 1'b1 || bus.Error !== 1'b0
            || bus.DatoSalida !== 7'd20)
            $display("FAIL error_1A v=%b e=%b d=%0d exp=1/0/20",
                     bus.SalidaValida, bus.Error, bus.DatoSalida);
        else passed++;
`endif
        tick();
        // A clean word right after must not inherit the flag
        bus.DatoEntrada   = 8'h36;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b1 || bus.Error !== 1'b0
            || bus.DatoSalida !== 7'd36)
            $display("FAIL error_clear v=%b e=%b d=%0d exp=1/0/36",
                     bus.SalidaValida, bus.Error, bus.DatoSalida);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        bus.SalidaLista   = 1'b0;
        bus.DatoEntrada   = 8'h42;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        tick();
        tick();
        bus.DatoEntrada   = 8'h77;
        bus.EntradaValida = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.SalidaValida !== 1'b1 || bus.DatoSalida !== 7'd42
                || bus.EntradaLista !== 1'b0)
                $display("FAIL bp_hold cyc=%0d v=%b d=%0d l=%b exp=1/42/0",
                         i, bus.SalidaValida, bus.DatoSalida,
                         bus.EntradaLista);
            else passed++;
            tick();
        end
        checks++;
        if (bus.DatoSalida !== 7'd42 || bus.SalidaValida !== 1'b1)
            $display("FAIL bp_pretake d=%0d v=%b exp=42/1",
                     bus.DatoSalida, bus.SalidaValida);
        else passed++;
        bus.EntradaValida = 1'b0;
        bus.SalidaLista   = 1'b1;
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b0 || bus.EntradaLista !== 1'b1)
            $display("FAIL bp_take v=%b l=%b exp=0/1",
                     bus.SalidaValida, bus.EntradaLista);
        else passed++;
        tick();
        tick();
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b0 || bus.EntradaLista !== 1'b1)
            $display("FAIL bp_ignored v=%b l=%b exp=0/1",
                     bus.SalidaValida, bus.EntradaLista);
        else passed++;
    endtask

    task automatic test_reset_vuelo();
        bus.SalidaLista   = 1'b1;
        bus.DatoEntrada   = 8'h99;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        tick();
        // mid-cycle, far from any clock edge
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.SalidaValida !== 1'b0 || bus.DatoSalida !== 7'd0
            || bus.Error !== 1'b0 || bus.EntradaLista !== 1'b1)
            $display("FAIL rst_async v=%b d=%0d e=%b l=%b exp=0/0/0/1",
                     bus.SalidaValida, bus.DatoSalida, bus.Error,
                     bus.EntradaLista);
        else passed++;
        tick();
        rst = 1'b0;
        bus.DatoEntrada   = 8'h07;
        bus.EntradaValida = 1'b1;
        tick();
        bus.EntradaValida = 1'b0;
        checks++;
        if (bus.EntradaLista !== 1'b0 || bus.SalidaValida !== 1'b0)
            $display("FAIL rst_accept l=%b v=%b exp=0/0",
                     bus.EntradaLista, bus.SalidaValida);
        else passed++;
        tick();
        tick();
        checks++;
        if (bus.SalidaValida !== 1'b1 || bus.DatoSalida !== 7'd7
            || bus.Error !== 1'b0)
            $display("FAIL rst_after v=%b d=%0d e=%b exp=1/7/0",
                     bus.SalidaValida, bus.DatoSalida, bus.Error);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_basico();
        test_barrido();
        test_error();
        test_backpressure();
        test_reset_vuelo();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/codificador_bcd.md
# codificador_bcd

Sequential packed-BCD-to-binary converter: takes a DIGITOS-digit packed BCD word and returns its binary value. It uses one multiply-by-10-and-add step per digit, most significant digit first. It sits on the input side of the datapath, turning BCD operands (keypad or display-format values) back into binary. Both sides use a valid/ready handshake.

## Interface
- DIGITOS, default 2: number of BCD digits in DatoEntrada; range 1–4.
- ANCHO, default 7: binary output width. Must satisfy 2^ANCHO ≥ 10^DIGITOS.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- DatoEntrada  input  4*DIGITOS  packed BCD; digit i is bits [4i+3:4i]; top nibble is the most significant digit.
- EntradaValida  input  1  DatoEntrada holds a word to convert.
- EntradaLista  output  1  block can accept a word.
- DatoSalida  output  ANCHO  binary result.
- SalidaValida  output  1  DatoSalida/Error hold a finished result.
- SalidaLista  input  1  consumer takes the result.
- Error  output  1  a nibble > 9 was seen during this conversion; only meaningful with SalidaValida.

## Operation
- FSM states: INACTIVO, CONVIRTIENDO, LISTO.
- INACTIVO:
  - EntradaLista=1.
  - On EntradaValida&&EntradaLista at a clock edge, latch DatoEntrada into a shift register and clear the accumulator and error flag.
  - Load the digit counter with DIGITOS and go to CONVIRTIENDO.
- CONVIRTIENDO, one digit per cycle:
  - acc ← (acc<<3)+(acc<<1)+top nibble, truncated to ANCHO bits.
  - Shift register moves left 4 bits; counter decrements.
  - When the counter reaches 0 after the update, go to LISTO.
- LISTO:
  - SalidaValida=1. DatoSalida and Error stay stable until SalidaLista=1 at an edge, then go to INACTIVO.
- EntradaLista=0 in CONVIRTIENDO and LISTO. EntradaValida there is ignored, and the word is not captured.
- DatoEntrada is read only at the accept edge; later changes have no effect.
- Arithmetic is unsigned. Intermediate products wider than ANCHO are truncated. This cannot occur for valid BCD under the ANCHO rule.

## Timing
- Reset values: every output is 0 (DatoSalida, SalidaValida, Error) except EntradaLista, which is 1 because the state is INACTIVO. Accumulator, shift register and counter are 0.
- Latency: word accepted at edge k, SalidaValida=1 after edge k+DIGITOS.
- Minimum period between accepts is DIGITOS+2 cycles when SalidaLista is held at 1.
- Backpressure: with SalidaLista=0, LISTO is held indefinitely with a stable result.
- rst asserted in any state returns to INACTIVO immediately, without waiting for a clock. Any in-flight word is discarded with no output. First accept is possible at the first edge after rst deasserts.
- Outputs are registered; no combinational path from input to output except EntradaLista, which is decoded from the state.

## Configuration
- CODIFICADOR_BCD_VERIFICA_EN defined:
  - Each nibble is checked as it is consumed. Any nibble > 9 sets the error flag, which stays set for the rest of the conversion.
  - In LISTO with the flag set: Error=1 and DatoSalida=0.
- Not defined:
  - No check is made. Error is tied to 0.
  - Nibbles 10–15 are used at face value in the multiply-add.

## Test plan
- DIGITOS=2, SalidaLista=1, accept 8'h15 → SalidaValida after 2 edges, DatoSalida=15, Error=0; EntradaLista returns to 1 one cycle later.
- Sweep all valid words 8'h00–8'h99 back-to-back → DatoSalida equals the decimal value each time, Error=0, one result per 4 cycles.
- 8'h1A:
  - with CODIFICADOR_BCD_VERIFICA_EN → Error=1, DatoSalida=0;
  - without it → Error=0, DatoSalida=20.
- 8'h42 accepted, SalidaLista=0 for 5 cycles → DatoSalida=42 held stable, EntradaLista=0, a new EntradaValida with 8'h77 is ignored; result 42 is taken at the edge where SalidaLista rises.
- Accept 8'h99, assert rst one cycle later → outputs 0 immediately, EntradaLista=1; after release, accept 8'h07 → DatoSalida=7, no trace of 99.
